// File: rtl/instr_fetch_sequencer.sv
// Non-pipelined fetch sequencer: fetches one word, issues it to decode/execute,
// then advances or redirects the PC once execute retires it.
module instr_fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                OPC_LSB  = 26,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  input  logic               ex_done,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [31:0]        retired_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic [31:0]         r_retired;
  logic                w_fetch_done;
  logic                w_retire;
  logic [ADDR_W-1:0]   w_br_aligned;
  logic [ADDR_W-1:0]   w_pc_nxt;

  assign w_fetch_done = (r_state == S_FETCH) && imem_ready;
  assign w_retire     = (r_state == S_ISSUE) && ex_done;
  // Redirects are forced word-aligned by clearing the two low address bits.
  assign w_br_aligned = branch_target & ~ADDR_W'(3);
  assign w_pc_nxt     = branch_taken ? w_br_aligned : (r_pc + ADDR_W'(PC_STEP));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (run) w_state_nxt = S_FETCH;
      S_FETCH:  if (imem_ready) w_state_nxt = S_ISSUE;
      S_ISSUE:  if (ex_done) w_state_nxt = halt ? S_HALTED : S_FETCH;
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      if (w_fetch_done) begin
        r_instr <= imem_rdata;
      end
      if (w_retire && !halt) begin
        r_pc <= w_pc_nxt;
      end
      if (w_retire && (r_retired != '1)) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign instr_out   = r_instr;
  assign opcode      = r_instr[OPC_LSB+5:OPC_LSB];
  assign instr_valid = (r_state == S_ISSUE);
  assign halted      = (r_state == S_HALTED);
  assign pc          = r_pc;
  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer; issued instructions are checked by a
// scoreboard monitor that pops an expected {address, retired count} per issue.
module tb_instr_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr_out;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        ex_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] retired_cnt;

  logic        mem_en;
  logic        mem_rdy_auto;
  logic        man_rdy;
  int          wcnt;
  int          cyc;
  int          tests;
  int          fails;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ret;
  } exp_t;
  exp_t q[$];

  assign imem_ready = mem_rdy_auto | man_rdy;

  instr_fetch_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instr_out(instr_out), .opcode(opcode),
    .instr_valid(instr_valid), .ex_done(ex_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .pc(pc), .halted(halted),
    .retired_cnt(retired_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Opcode field comes from address bits [7:2], so 0xFC carries opcode 6'h3F.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = {a[7:2], a[27:2] ^ 26'h1555AAA};
  endfunction

  function automatic int ws_for(input logic [31:0] a);
    ws_for = (a == 32'h10) ? 3 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] r);
    exp_t e;
    e.addr = a;
    e.ret  = r;
    q.push_back(e);
  endtask

  task automatic wait_issue(output int t);
    int n;
    n = 0;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!instr_valid) begin
      fails++;
      $display("FAIL issue_timeout: instr_valid still 0 after %0d cycles, expected 1", n);
    end
    t = cyc;
  endtask

  task automatic retire(input logic br, input logic [31:0] tgt, input logic h);
    ex_done       = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    halt          = h;
    @(negedge clk);
    ex_done      = 1'b0;
    branch_taken = 1'b0;
    halt         = 1'b0;
  endtask

  // Memory responder: answers each request after ws_for(addr) wait states.
  initial begin
    mem_rdy_auto = 1'b0;
    imem_rdata   = 32'hDEADBEEF;
    wcnt         = 0;
    forever begin
      @(negedge clk);
      if (mem_en && imem_req && !mem_rdy_auto) begin
        if (wcnt >= ws_for(imem_addr)) begin
          mem_rdy_auto = 1'b1;
          imem_rdata   = mem_word(imem_addr);
          wcnt         = 0;
        end else begin
          wcnt++;
        end
      end else begin
        mem_rdy_auto = 1'b0;
        imem_rdata   = 32'hDEADBEEF;
      end
    end
  end

  // Scoreboard monitor: one expected entry per entry into the issue state.
  initial begin
    logic        prev_valid;
    exp_t        e;
    logic [31:0] w;
    logic [5:0]  op;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (instr_valid && !prev_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: issue at pc 0x%0h, expected no issue", pc);
        end else begin
          e  = q.pop_front();
          w  = mem_word(e.addr);
          op = w[31:26];
          if (pc !== e.addr || instr_out !== w || opcode !== op || retired_cnt !== e.ret) begin
            fails++;
            $display("FAIL sb_issue: pc 0x%0h instr 0x%0h op 0x%0h ret %0d, expected pc 0x%0h instr 0x%0h op 0x%0h ret %0d",
                     pc, instr_out, opcode, retired_cnt, e.addr, w, op, e.ret);
          end
        end
      end
      prev_valid = instr_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    int n;
    int bad;
    tests = 0; fails = 0;
    reset = 1'b0; run = 1'b0; mem_en = 1'b0; man_rdy = 1'b0;
    ex_done = 1'b0; branch_taken = 1'b0; branch_target = '0; halt = 1'b0;

    // Reset state, then reset asserted mid-FETCH while imem_ready pulses
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_retired", retired_cnt, 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    reset = 1'b1;
    @(negedge clk); run = 1'b1;
    @(negedge clk);
    chk("t1_fetch_req", {31'd0, imem_req}, 32'd1);
    chk("t1_fetch_addr", imem_addr, 32'h0);
    run = 1'b0;
    @(negedge clk);
    man_rdy = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("t1_async_req", {31'd0, imem_req}, 32'd0);
    chk("t1_async_pc", pc, 32'h0);
    @(negedge clk);
    man_rdy = 1'b0;
    chk("t1_hold_valid", {31'd0, instr_valid}, 32'd0);
    chk("t1_hold_instr", instr_out, 32'h0);
    chk("t1_hold_retired", retired_cnt, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("t1_idle_req", {31'd0, imem_req}, 32'd0);

    // Three sequential instructions, zero wait states, 2 cycles each
    mem_en = 1'b1;
    push(32'h0, 0); push(32'h4, 1); push(32'h8, 2);
    run = 1'b1;
    wait_issue(t0); retire(1'b0, '0, 1'b0);
    wait_issue(t1); chk("t2_period_a", t1 - t0, 2); retire(1'b0, '0, 1'b0);
    wait_issue(t0); chk("t2_period_b", t0 - t1, 2); retire(1'b0, '0, 1'b0);
    chk("t2_retired", retired_cnt, 32'd3);
    chk("t2_pc", pc, 32'hC);

    // Three wait states at 0x10: request held 4 cycles, instr_out held until ready
    push(32'hC, 3);
    wait_issue(t0); retire(1'b0, '0, 1'b0);
    push(32'h10, 4);
    n = 0; bad = 0;
    while (imem_req && n < 50) begin
      if (imem_addr !== 32'h10 || instr_out !== mem_word(32'hC)) bad++;
      n++;
      @(negedge clk);
    end
    chk("t3_req_cycles", n, 4);
    chk("t3_hold_errors", bad, 0);
    wait_issue(t0);
    chk("t3_instr", instr_out, mem_word(32'h10));

    // Branch alignment and PC wrap
    push(32'h40, 5);
    retire(1'b1, 32'h43, 1'b0);
    chk("t4_branch_pc", pc, 32'h40);
    wait_issue(t0);
    push(32'hFFFFFFFC, 6);
    retire(1'b1, 32'hFFFFFFFC, 1'b0);
    wait_issue(t0);
    push(32'h0, 7);
    retire(1'b0, '0, 1'b0);
    chk("t4_wrap_pc", pc, 32'h0);
    wait_issue(t0);

    // imem_ready during ISSUE and ex_done during FETCH are ignored
    man_rdy = 1'b1;
    repeat (2) @(negedge clk);
    man_rdy = 1'b0;
    chk("t6_issue_valid", {31'd0, instr_valid}, 32'd1);
    chk("t6_issue_pc", pc, 32'h0);
    chk("t6_issue_instr", instr_out, mem_word(32'h0));
    push(32'h4, 8);
    retire(1'b0, '0, 1'b0);
    ex_done = 1'b1; branch_taken = 1'b1; branch_target = 32'h80; halt = 1'b1;
    @(negedge clk);
    ex_done = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    chk("t6_fetch_pc", pc, 32'h4);
    chk("t6_fetch_retired", retired_cnt, 32'd8);
    chk("t6_fetch_halted", {31'd0, halted}, 32'd0);
    chk("t6_fetch_valid", {31'd0, instr_valid}, 32'd1);

    // Halt on an all-ones opcode; run is ignored once halted
    push(32'hFC, 9);
    retire(1'b1, 32'hFC, 1'b0);
    wait_issue(t0);
    chk("t5_opcode", {26'd0, opcode}, 32'h3F);
    retire(1'b1, 32'h200, 1'b1);
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_pc", pc, 32'hFC);
    chk("t5_retired", retired_cnt, 32'd10);
    run = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1) bad++;
    end
    chk("t5_halt_hold", bad, 0);
    chk("t5_retired_final", retired_cnt, 32'd10);
    chk("sb_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
